// File: rtl/mux_scan_tdm_if.sv
`default_nettype none
// ============================================================================
// mux_scan_tdm_if : lane bank / consumer bus for the scanning TDM multiplexer
// Revision: 1.0
// ============================================================================
interface mux_scan_tdm_if #(
  parameter int NCH = 16,
  parameter int W   = 1
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*W-1:0] in;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [NCH-1:0]   en_mask;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             frame_start;

  modport master (
    output in, mode, sel, en_mask, out_ready,
    input  out_valid, out_data, out_ch, frame_start
  );

  modport slave (
    input  in, mode, sel, en_mask, out_ready,
    output out_valid, out_data, out_ch, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_tdm.sv
`default_nettype none
// ============================================================================
// mux_scan_tdm : registered N:1 mux with manual select or round-robin scan
// Revision: 1.0
// ============================================================================
module mux_scan_tdm #(
  parameter int NCH = 16,
  parameter int W   = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mux_scan_tdm_if.slave bus
);
  localparam int SELW = $clog2(NCH);

  logic            r_valid;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_ch;
  logic            r_frame;
  logic [SELW-1:0] r_ptr;
  logic            r_restart;

  logic            w_load;
  logic            w_any;
  logic            w_found_hi;
  logic [SELW-1:0] w_low;
  logic [SELW-1:0] w_hi;
  logic [SELW-1:0] w_scan_ch;
  logic [W-1:0]    w_man_data;
  logic [W-1:0]    w_scan_data;

  assign w_load = !r_valid || bus.out_ready;

  // Descending walk: the last hit is the lowest enabled index overall and
  // the lowest enabled index above the scan pointer.
  always_comb begin
    w_any      = 1'b0;
    w_found_hi = 1'b0;
    w_low      = '0;
    w_hi       = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (bus.en_mask[k]) begin
        w_any = 1'b1;
        w_low = SELW'(k);
        if (SELW'(k) > r_ptr) begin
          w_found_hi = 1'b1;
          w_hi       = SELW'(k);
        end
      end
    end
  end

  assign w_scan_ch = (r_restart || !w_found_hi) ? w_low : w_hi;

  // Out-of-range manual selects match no channel and read as zero.
  always_comb begin
    w_man_data  = '0;
    w_scan_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.sel == SELW'(k)) w_man_data = bus.in[k*W +: W];
      if (w_scan_ch == SELW'(k)) w_scan_data = bus.in[k*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_ch      <= '0;
      r_frame   <= 1'b0;
      r_ptr     <= SELW'(NCH - 1);
      r_restart <= 1'b1;
    end else if (w_load) begin
      if (!bus.mode) begin
        r_valid   <= 1'b1;
        r_data    <= w_man_data;
        r_ch      <= bus.sel;
        r_frame   <= 1'b0;
        r_restart <= 1'b1;
      end else if (!w_any) begin
        r_valid <= 1'b0;
      end else begin
        r_valid   <= 1'b1;
        r_data    <= w_scan_data;
        r_ch      <= w_scan_ch;
        r_ptr     <= w_scan_ch;
        r_frame   <= (w_scan_ch == w_low);
        r_restart <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_data    = r_data;
  assign bus.out_ch      = r_ch;
  assign bus.frame_start = r_frame;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_tdm.sv
`default_nettype none
// ============================================================================
// tb_mux_scan_tdm : directed and randomized checks against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_mux_scan_tdm;
  localparam int NCH  = 16;
  localparam int W    = 1;
  localparam int SELW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] pat = 16'hEC9A;

  mux_scan_tdm_if #(.NCH(NCH), .W(W)) bus ();
  mux_scan_tdm #(.NCH(NCH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  // Reference model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  logic         m_frame;
  int           m_ptr;
  bit           m_restart;

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_frame = 1'b0;
    m_ptr = NCH - 1; m_restart = 1'b1;
  endtask

  // Advance the model with the inputs presented before the edge, then clock.
  task automatic tick();
    int  en[$];
    int  c;
    bit  found;
    if (!m_valid || bus.out_ready) begin
      if (!bus.mode) begin
        m_ch      = int'(bus.sel);
        m_data    = (m_ch < NCH) ? bus.in[m_ch*W +: W] : '0;
        m_valid   = 1'b1;
        m_frame   = 1'b0;
        m_restart = 1'b1;
      end else begin
        for (int i = 0; i < NCH; i++) if (bus.en_mask[i]) en.push_back(i);
        if (en.size() == 0) begin
          m_valid = 1'b0;
        end else begin
          c = en[0];
          found = 1'b0;
          if (!m_restart)
            foreach (en[i]) if (!found && en[i] > m_ptr) begin c = en[i]; found = 1'b1; end
          m_ch      = c;
          m_ptr     = c;
          m_data    = bus.in[c*W +: W];
          m_frame   = (c == en[0]);
          m_valid   = 1'b1;
          m_restart = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in = '0; bus.mode = 1'b0; bus.sel = '0; bus.en_mask = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset: got v=%b d=%h ch=%0d fs=%b, expected all zero",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    int sels[6] = '{9, 4, 5, 11, 1, 14};
    logic exp_d[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in = pat;
    for (int i = 0; i < 6; i++) begin
      bus.sel = SELW'(sels[i]);
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !==
          {1'b1, exp_d[i], SELW'(sels[i]), 1'b0}) begin
        n_errors++;
        $display("FAIL manual[%0d]: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=%h ch=%0d fs=0",
                 i, bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start, exp_d[i], sels[i]);
      end
    end
  endtask

  task automatic test_scan_full();
    int ch;
    bus.mode = 1'b1; bus.en_mask = 16'hFFFF; bus.out_ready = 1'b1; bus.in = pat;
    for (int i = 0; i <= NCH; i++) begin
      tick();
      ch = i % NCH;
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !==
          {1'b1, pat[ch], SELW'(ch), (ch == 0)}) begin
        n_errors++;
        $display("FAIL scan_full[%0d]: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=%b ch=%0d fs=%b",
                 i, bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start, pat[ch], ch, ch == 0);
      end
    end
  endtask

  task automatic test_scan_sparse();
    int seq[8] = '{1, 4, 9, 1, 4, 4, 4, 4};
    bus.mode = 1'b1; bus.en_mask = 16'h0212; bus.out_ready = 1'b1; bus.in = pat;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) bus.en_mask = 16'h0010;
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !==
          {1'b1, pat[seq[i]], SELW'(seq[i]), (seq[i] == 1 || i >= 5)}) begin
        n_errors++;
        $display("FAIL scan_sparse[%0d]: got v=%b d=%h ch=%0d fs=%b, expected ch=%0d",
                 i, bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start, seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit reached = 1'b0;
    bus.mode = 1'b1; bus.en_mask = 16'hFFFF; bus.out_ready = 1'b1; bus.in = pat;
    for (int i = 0; i < 20 && !reached; i++) begin
      tick();
      if (m_ch == 3 && m_valid) reached = 1'b1;
    end
    n_checks++;
    if (!reached || bus.out_ch !== 4'd3) begin
      n_errors++;
      $display("FAIL bp_reach: got ch=%0d, expected ch=3 within 20 cycles", bus.out_ch);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in = (NCH*W)'($urandom);
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, pat[3], 4'd3, 1'b0}) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=%b ch=3 fs=0",
                 i, bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start, pat[3]);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, m_data, 4'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL bp_release: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=%h ch=4 fs=0",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start, m_data);
    end
    bus.in = pat;
  endtask

  task automatic test_mask_zero();
    bus.mode = 1'b1; bus.en_mask = '0; bus.out_ready = 1'b1; bus.in = pat;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mask_zero: got v=%b, expected v=0", bus.out_valid);
    end
    bus.en_mask = 16'h8000;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, pat[15], 4'd15, 1'b1}) begin
      n_errors++;
      $display("FAIL mask_single: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=1 ch=15 fs=1",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
    bus.mode = 1'b0; bus.sel = 4'd2;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, pat[2], 4'd2, 1'b0}) begin
      n_errors++;
      $display("FAIL mode_manual: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=0 ch=2 fs=0",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
    bus.mode = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, pat[15], 4'd15, 1'b1}) begin
      n_errors++;
      $display("FAIL mode_rescan: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=1 ch=15 fs=1",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      bus.in        = (NCH*W)'($urandom);
      bus.mode      = ($urandom_range(0, 4) != 0);
      bus.sel       = SELW'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r == 0)      bus.en_mask = '0;
      else if (r == 1) bus.en_mask = NCH'(1) << $urandom_range(0, NCH - 1);
      else if (r < 5)  bus.en_mask = bus.en_mask;
      else             bus.en_mask = NCH'($urandom);
      tick();
      n_checks++;
      if (bus.out_valid !== m_valid ||
          (m_valid && {bus.out_data, bus.out_ch, bus.frame_start} !== {m_data, SELW'(m_ch), m_frame})) begin
        n_errors++;
        $display("FAIL random[%0d]: got v=%b d=%h ch=%0d fs=%b, expected v=%b d=%h ch=%0d fs=%b",
                 i, bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start,
                 m_valid, m_data, m_ch, m_frame);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.mode = 1'b1; bus.en_mask = 16'hFFFF; bus.out_ready = 1'b1; bus.in = pat;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== SELW'(m_ch)) begin
      n_errors++;
      $display("FAIL ar_stall: got v=%b ch=%0d, expected v=1 ch=%0d", bus.out_valid, bus.out_ch, m_ch);
    end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== 7'b0) begin
      n_errors++;
      $display("FAIL ar_assert: got v=%b d=%h ch=%0d fs=%b, expected all zero",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start} !== {1'b1, pat[0], 4'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL ar_restart: got v=%b d=%h ch=%0d fs=%b, expected v=1 d=0 ch=0 fs=1",
               bus.out_valid, bus.out_data, bus.out_ch, bus.frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_full();
    test_scan_sparse();
    test_backpressure();
    test_mask_zero();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end
endmodule
`default_nettype wire
